// File: rtl/truth_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : truth_seq_pkg
//  Description : Shared types and sizing constants for the truth-table
//                sequencer: FSM state encoding, vector count, index width
//                and counter width (settle counter and fail counter).
//  Contents    : state_e, VEC_COUNT, IDX_W, CNT_W
//  Revision    : 1.0 - initial release
// ============================================================================
package truth_seq_pkg;

    localparam int VEC_COUNT = 8;
    localparam int IDX_W     = 3;
    localparam int CNT_W     = 4;

    // Members carry an ST_ prefix so they cannot collide with the SETTLE
    // parameter of the sequencer, which would otherwise shadow them.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage : truth_seq_pkg
`default_nettype wire

// File: rtl/truth_table_sequencer_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : settle_timer
//  Description : Loadable down-counter. Load takes priority; otherwise the
//                count decrements while enabled and stops at zero.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                load_i, value_i - load request and load value
//                en_i            - decrement enable
//                zero_o          - count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module settle_timer
    import truth_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule : settle_timer
`default_nettype wire

// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sequencer
//  Description : Drives {A,B,C} through indices 0..7, waits SETTLE cycles,
//                samples F and compares it to EXPECTED[idx]. Reports the
//                mismatch count, the first failing index and overall pass.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                start              - begin a sweep (IDLE or DONE only)
//                A, B, C            - stimulus, A is the index MSB
//                F                  - response from the unit under test
//                busy, done, pass   - sweep status
//                fail_count         - mismatches this sweep (0..8)
//                first_fail_valid/_idx - first mismatch diagnostics
//                sample_valid/_idx  - one-cycle compare strobe and index
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sequencer
    import truth_seq_pkg::*;
#(
    parameter logic [7:0]  EXPECTED = 8'b1110_1000,
    parameter int unsigned SETTLE   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             A,
    output logic             B,
    output logic             C,
    input  logic             F,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic             first_fail_valid,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic             sample_valid,
    output logic [IDX_W-1:0] sample_idx
);

    localparam bit               c_HAS_SETTLE  = (SETTLE != 0);
    // Guarded so SETTLE=0 does not produce an underflowed load value.
    localparam logic [CNT_W-1:0] c_SETTLE_LOAD = c_HAS_SETTLE ? CNT_W'(SETTLE - 1) : '0;
    localparam logic [IDX_W-1:0] c_LAST_IDX    = IDX_W'(VEC_COUNT - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             ffv_q, ffv_d;
    logic [IDX_W-1:0] ffi_q, ffi_d;
    logic             busy_q, done_q, pass_q, sv_q;
    logic [IDX_W-1:0] sidx_q;

    logic             tmr_load, tmr_en, tmr_zero;

    settle_timer u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .value_i (c_SETTLE_LOAD),
        .en_i    (tmr_en),
        .zero_o  (tmr_zero)
    );

    // ------------------------------------------------------------------
    // Next-state and result-update logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fail_d   = fail_q;
        ffv_d    = ffv_q;
        ffi_d    = ffi_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_APPLY;
                    idx_d   = '0;
                    fail_d  = '0;
                    ffv_d   = 1'b0;
                    ffi_d   = '0;
                end
            end
            ST_APPLY: begin
                // Loading on the APPLY->SETTLE edge makes the counter hit
                // zero in the SETTLE-th cycle of the SETTLE state.
                tmr_load = 1'b1;
                state_d  = c_HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (F != EXPECTED[idx_q]) begin
                    fail_d = fail_q + CNT_W'(1);
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = idx_q;
                    end
                end
                if (idx_q == c_LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_APPLY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs; status flags are derived from the
    // next state so they line up with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            fail_q  <= '0;
            ffv_q   <= 1'b0;
            ffi_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            sv_q    <= 1'b0;
            sidx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fail_q  <= fail_d;
            ffv_q   <= ffv_d;
            ffi_q   <= ffi_d;
            busy_q  <= (state_d == ST_APPLY) || (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
            done_q  <= (state_d == ST_DONE);
            pass_q  <= (state_d == ST_DONE) && (fail_d == '0);
            sv_q    <= (state_d == ST_SAMPLE);
            if (state_d == ST_SAMPLE) begin
                sidx_q <= idx_d;
            end
        end
    end

    // idx only changes on edges entering APPLY, so the stimulus does too.
    assign A                = idx_q[2];
    assign B                = idx_q[1];
    assign C                = idx_q[0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;
    assign sample_valid     = sv_q;
    assign sample_idx       = sidx_q;

endmodule : truth_table_sequencer
`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_sequencer
//  Description : Directed bench. dut_a uses SETTLE=2, dut_b uses SETTLE=0;
//                both use the default majority truth table. F for each DUT
//                comes from a behavioural unit model with selectable faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sequencer;
    import truth_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b;
    int   mode_a, mode_b;
    int   sel;
    int   checks = 0;
    int   errors = 0;

    logic       a_A, a_B, a_C, a_F, a_busy, a_done, a_pass, a_ffv, a_sv;
    logic [3:0] a_fc;
    logic [2:0] a_ffi, a_sidx;
    logic       b_A, b_B, b_C, b_F, b_busy, b_done, b_pass, b_ffv, b_sv;
    logic [3:0] b_fc;
    logic [2:0] b_ffi, b_sidx;

    // Unit models: 0 majority, 1 majority with index 5 inverted,
    // 2 stuck-at-0, 3 stuck-at-1.
    function automatic logic unit_model(input logic [2:0] v, input int mode);
        logic maj;
        maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
        case (mode)
            1:       return maj ^ (v == 3'd5);
            2:       return 1'b0;
            3:       return 1'b1;
            default: return maj;
        endcase
    endfunction

    assign a_F = unit_model({a_A, a_B, a_C}, mode_a);
    assign b_F = unit_model({b_A, b_B, b_C}, mode_b);

    truth_table_sequencer #(.EXPECTED(8'b1110_1000), .SETTLE(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .A(a_A), .B(a_B), .C(a_C), .F(a_F),
        .busy(a_busy), .done(a_done), .pass(a_pass), .fail_count(a_fc),
        .first_fail_valid(a_ffv), .first_fail_idx(a_ffi),
        .sample_valid(a_sv), .sample_idx(a_sidx)
    );

    truth_table_sequencer #(.EXPECTED(8'b1110_1000), .SETTLE(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .A(b_A), .B(b_B), .C(b_C), .F(b_F),
        .busy(b_busy), .done(b_done), .pass(b_pass), .fail_count(b_fc),
        .first_fail_valid(b_ffv), .first_fail_idx(b_ffi),
        .sample_valid(b_sv), .sample_idx(b_sidx)
    );

    // View of whichever DUT the current scenario targets.
    logic [2:0] s_abc, s_ffi, s_sidx;
    logic [3:0] s_fc;
    logic       s_busy, s_done, s_pass, s_ffv, s_sv;
    assign s_abc  = (sel == 0) ? {a_A, a_B, a_C} : {b_A, b_B, b_C};
    assign s_busy = (sel == 0) ? a_busy : b_busy;
    assign s_done = (sel == 0) ? a_done : b_done;
    assign s_pass = (sel == 0) ? a_pass : b_pass;
    assign s_fc   = (sel == 0) ? a_fc   : b_fc;
    assign s_ffv  = (sel == 0) ? a_ffv  : b_ffv;
    assign s_ffi  = (sel == 0) ? a_ffi  : b_ffi;
    assign s_sv   = (sel == 0) ? a_sv   : b_sv;
    assign s_sidx = (sel == 0) ? a_sidx : b_sidx;

    // Advance one clock; observation point is 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start_a = v;
        else          start_b = v;
    endtask

    // Runs one sweep on the selected DUT. pv is the per-vector cycle cost.
    // c counts cycles from the edge that accepts start (c=0 is APPLY of
    // vector 0). Vector k is sampled at c = k*pv + pv-1, done rises at
    // c = 8*pv (i.e. the 33rd cycle counting the start cycle for pv=4).
    task automatic run_sweep(input string name, input int pv, input bit restart9,
                             input int exp_fc, input bit exp_ffv, input logic [2:0] exp_ffi);
        int  c;
        int  nsamp;
        bit  got_done;
        set_start(1'b1);
        step();
        set_start(1'b0);
        c = 0;
        checks++;
        if (s_abc !== 3'b000 || s_busy !== 1'b1 || s_done !== 1'b0) begin
            errors++;
            $display("FAIL %s start: abc=%b busy=%b done=%b, want abc=000 busy=1 done=0",
                     name, s_abc, s_busy, s_done);
        end
        checks++;
        if (s_fc !== 4'd0 || s_ffv !== 1'b0 || s_ffi !== 3'd0 || s_pass !== 1'b0) begin
            errors++;
            $display("FAIL %s cleared: fc=%0d ffv=%b ffi=%0d pass=%b, want 0 0 0 0",
                     name, s_fc, s_ffv, s_ffi, s_pass);
        end
        nsamp    = 0;
        got_done = 1'b0;
        while (!got_done && c <= 8 * pv + 4) begin
            if (s_sv === 1'b1) begin
                checks++;
                if (s_sidx !== nsamp[2:0] || s_abc !== nsamp[2:0] || c != nsamp * pv + pv - 1) begin
                    errors++;
                    $display("FAIL %s sample%0d: idx=%0d abc=%b cycle=%0d, want idx=%0d cycle=%0d",
                             name, nsamp, s_sidx, s_abc, c, nsamp, nsamp * pv + pv - 1);
                end
                nsamp++;
            end
            if (s_done === 1'b1) begin
                got_done = 1'b1;
                checks++;
                if (c != 8 * pv || s_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_time: cycle=%0d busy=%b, want cycle=%0d busy=0",
                             name, c, s_busy, 8 * pv);
                end
            end else begin
                if (restart9 && c == 9) set_start(1'b1);
                step();
                set_start(1'b0);
                c++;
            end
        end
        checks++;
        if (!got_done || nsamp != 8) begin
            errors++;
            $display("FAIL %s completion: done_seen=%0d samples=%0d, want 1 and 8",
                     name, got_done, nsamp);
        end
        checks++;
        if (s_fc !== exp_fc[3:0] || s_ffv !== exp_ffv || s_ffi !== exp_ffi ||
            s_pass !== (exp_fc == 0) || s_abc !== 3'b111) begin
            errors++;
            $display("FAIL %s result: fc=%0d ffv=%b ffi=%0d pass=%b abc=%b, want fc=%0d ffv=%b ffi=%0d pass=%b abc=111",
                     name, s_fc, s_ffv, s_ffi, s_pass, s_abc, exp_fc, exp_ffv, exp_ffi, exp_fc == 0);
        end
        // DONE must hold without a new start.
        step();
        step();
        checks++;
        if (s_done !== 1'b1 || s_sv !== 1'b0 || s_fc !== exp_fc[3:0]) begin
            errors++;
            $display("FAIL %s hold: done=%b sv=%b fc=%0d, want done=1 sv=0 fc=%0d",
                     name, s_done, s_sv, s_fc, exp_fc);
        end
    endtask

    task automatic check_all_reset(input string name);
        checks++;
        if ({s_abc, s_busy, s_done, s_pass, s_fc, s_ffv, s_ffi, s_sv, s_sidx} !== 18'd0) begin
            errors++;
            $display("FAIL %s: abc=%b busy=%b done=%b pass=%b fc=%0d ffv=%b ffi=%0d sv=%b sidx=%0d, want all 0",
                     name, s_abc, s_busy, s_done, s_pass, s_fc, s_ffv, s_ffi, s_sv, s_sidx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        sel = 0;
        check_all_reset("reset_a");
        sel = 1;
        check_all_reset("reset_b");
        rst = 1'b0;
        step();
        sel = 0;
        check_all_reset("idle_a");
    endtask

    task automatic test_majority();
        sel = 0; mode_a = 0;
        run_sweep("majority", 4, 1'b0, 0, 1'b0, 3'd0);
    endtask

    task automatic test_index5_fault();
        sel = 0; mode_a = 1;
        run_sweep("idx5_fault", 4, 1'b0, 1, 1'b1, 3'd5);
    endtask

    task automatic test_stuck0();
        sel = 0; mode_a = 2;
        run_sweep("stuck0", 4, 1'b0, 4, 1'b1, 3'd3);
    endtask

    task automatic test_start_ignored();
        sel = 0; mode_a = 0;
        run_sweep("restart_ignored", 4, 1'b1, 0, 1'b0, 3'd0);
    endtask

    task automatic test_midsweep_reset();
        sel = 0; mode_a = 2;
        set_start(1'b1);
        step();
        set_start(1'b0);
        // Vector 4: APPLY at c=16, SETTLE at c=17..18.
        for (int i = 0; i < 17; i++) step();
        checks++;
        if (s_abc !== 3'd4 || s_busy !== 1'b1 || dut_a.state_q !== ST_SETTLE) begin
            errors++;
            $display("FAIL midreset_pre: abc=%b busy=%b state=%0d, want abc=100 busy=1 state=%0d",
                     s_abc, s_busy, dut_a.state_q, ST_SETTLE);
        end
        rst = 1'b1;
        step();
        check_all_reset("midreset_outputs");
        checks++;
        if (dut_a.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL midreset_state: state=%0d, want %0d", dut_a.state_q, ST_IDLE);
        end
        rst = 1'b0;
        step();
        mode_a = 0;
        run_sweep("after_reset", 4, 1'b0, 0, 1'b0, 3'd0);
    endtask

    task automatic test_settle_zero();
        sel = 1; mode_b = 3;
        run_sweep("settle0_stuck1", 2, 1'b0, 4, 1'b1, 3'd0);
        // Second sweep starts from DONE with non-zero results pending;
        // run_sweep checks they are cleared on the accepting edge.
        run_sweep("settle0_restart", 2, 1'b0, 4, 1'b1, 3'd0);
        mode_b = 0;
        run_sweep("settle0_majority", 2, 1'b0, 0, 1'b0, 3'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        mode_a  = 0;
        mode_b  = 0;
        sel     = 0;
        #1;
        test_reset();
        test_majority();
        test_index5_fault();
        test_stuck0();
        test_start_ignored();
        test_midsweep_reset();
        test_settle_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_truth_table_sequencer
`default_nettype wire
